// File: rtl/rnn_seq_ctrl.sv
// Drives one character sequence through the rnn accelerator bus: load elements, kick, wait, dense, poll, read.
// Latency 1 + N*(EMB_LEN+1+STEP_WAIT) + 1 + P + 1 cycles from start to res_valid; input stalls on in_valid, result held until res_ack.
module rnn_seq_ctrl #(
  parameter int EMB_BITS     = 2,
  parameter int LEN_W        = 8,
  parameter int STEP_WAIT    = 64,
  parameter int POLL_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] seq_len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             res_valid,
  input  logic             res_ack,
  output logic [15:0]      res_data,
  output logic             err,
  output logic             rnn_read,
  output logic             rnn_write,
  output logic [31:0]      rnn_addr,
  output logic [31:0]      rnn_wdata,
  input  logic [31:0]      rnn_rdata
);

  localparam int EMB_LEN = 1 << EMB_BITS;
  localparam int WCNT_W  = $clog2(STEP_WAIT + 1);
  localparam int PCNT_W  = $clog2(POLL_TIMEOUT + 1);
  localparam logic [EMB_BITS-1:0] IDX_LAST  = EMB_BITS'(EMB_LEN - 1);
  localparam logic [WCNT_W-1:0]   WCNT_LOAD = WCNT_W'(STEP_WAIT - 1);
  localparam logic [PCNT_W-1:0]   PCNT_LAST = PCNT_W'(POLL_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_IN, KICK, WAIT_STEP, DENSE_GO, POLL, READ_RES, DONE
  } state_t;

  state_t              state;
  logic [LEN_W-1:0]    rem;
  logic [EMB_BITS-1:0] idx;
  logic [WCNT_W-1:0]   wcnt;
  logic [PCNT_W-1:0]   pcnt;
  logic                unused_rdata;

  assign unused_rdata = ^rnn_rdata[31:16];
  assign busy         = (state != IDLE);
  assign in_ready     = (state == LOAD_IN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rem       <= '0;
      idx       <= '0;
      wcnt      <= '0;
      pcnt      <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          rem <= seq_len;
          err <= 1'b0;
          if (seq_len == '0) begin
            state <= DENSE_GO;
          end else begin
            idx   <= '0;
            state <= LOAD_IN;
          end
        end
        // idx parks on the last element rather than wrapping back to 0
        LOAD_IN: if (in_valid) begin
          if (idx == IDX_LAST) state <= KICK;
          else                 idx   <= idx + EMB_BITS'(1);
        end
        KICK: begin
          wcnt  <= WCNT_LOAD;
          state <= WAIT_STEP;
        end
        WAIT_STEP: begin
          if (wcnt == '0) begin
            rem <= rem - LEN_W'(1);
            if (rem == LEN_W'(1)) begin
              state <= DENSE_GO;
            end else begin
              idx   <= '0;
              state <= LOAD_IN;
            end
          end else begin
            wcnt <= wcnt - WCNT_W'(1);
          end
        end
        DENSE_GO: begin
          pcnt  <= '0;
          state <= POLL;
        end
        POLL: begin
          if (rnn_rdata[0]) begin
            state <= READ_RES;
          end else if (pcnt == PCNT_LAST) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            pcnt <= pcnt + PCNT_W'(1);
          end
        end
        READ_RES: begin
          res_data  <= rnn_rdata[15:0];
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (res_ack) begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rnn_read  = 1'b0;
    rnn_write = 1'b0;
    rnn_addr  = 32'd0;
    rnn_wdata = 32'd0;
    case (state)
      LOAD_IN: if (in_valid) begin
        rnn_write = 1'b1;
        rnn_addr  = 32'd1;
        rnn_wdata = {8'h00, 8'(idx), in_data};
      end
      KICK: begin
        rnn_write = 1'b1;
        rnn_addr  = 32'd0;
      end
      DENSE_GO: begin
        rnn_write = 1'b1;
        rnn_addr  = 32'd7;
      end
      POLL: begin
        rnn_read = 1'b1;
        rnn_addr = 32'd0;
      end
      READ_RES: begin
        rnn_read = 1'b1;
        rnn_addr = 32'd7;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rnn_seq_ctrl.sv
// Directed bench for rnn_seq_ctrl with a small behavioural rnn bus responder and a write log.
module tb_rnn_seq_ctrl;

  localparam int STEP_WAIT    = 64;
  localparam int POLL_TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, res_ack;
  logic [7:0]  seq_len;
  logic [15:0] in_data;
  logic        busy, in_ready, res_valid, err, rnn_read, rnn_write;
  logic [15:0] res_data;
  logic [31:0] rnn_addr, rnn_wdata, rnn_rdata;

  rnn_seq_ctrl #(.EMB_BITS(2), .LEN_W(8), .STEP_WAIT(STEP_WAIT), .POLL_TIMEOUT(POLL_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .seq_len(seq_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .res_valid(res_valid), .res_ack(res_ack), .res_data(res_data), .err(err),
    .rnn_read(rnn_read), .rnn_write(rnn_write), .rnn_addr(rnn_addr),
    .rnn_wdata(rnn_wdata), .rnn_rdata(rnn_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] din;
    logic [31:0] addr;
    logic [31:0] wdata;
  } vec_t;

  wr_t         wq[$];
  int          cyc = 0, poll_cnt = 0, both_cnt = 0;
  int          poll_base = 0, poll_hit = 0, wbase = 0;
  logic [31:0] res_word = '0;
  int          passed = 0, total = 0;

  // Bus observer: one entry per write strobe, one count per status poll.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rnn_write) wq.push_back('{cyc, rnn_addr, rnn_wdata});
    if (rnn_read && rnn_addr == 32'd0) poll_cnt = poll_cnt + 1;
    if (rnn_read && rnn_write) both_cnt = both_cnt + 1;
  end

  // rnn responder: VALID appears on the poll_hit-th poll; addr 7 returns res_word.
  always_comb begin
    rnn_rdata = '0;
    if (rnn_read && rnn_addr == 32'd0)
      rnn_rdata[0] = (poll_hit != 0) && ((poll_cnt - poll_base) == poll_hit);
    else if (rnn_read && rnn_addr == 32'd7)
      rnn_rdata = res_word;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_test(input int hit, input logic [31:0] rw);
    poll_hit  = hit;
    res_word  = rw;
    poll_base = poll_cnt;
    wbase     = wq.size();
  endtask

  task automatic do_start(input logic [7:0] len);
    start   = 1'b1;
    seq_len = len;
    tick();
    start   = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input bit gap);
    int n;
    n        = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    tick();
    if (gap) begin
      in_valid = 1'b0;
      tick();
    end
  endtask

  task automatic wait_res(input string name);
    int n;
    n = 0;
    while (!res_valid && n < 3000) begin
      tick();
      n++;
    end
    check(name, 32'(res_valid), 32'd1);
  endtask

  task automatic ack();
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
  endtask

  function automatic int n_writes(input logic [31:0] a);
    int m = 0;
    for (int i = wbase; i < wq.size(); i++) if (wq[i].addr == a) m++;
    return m;
  endfunction

  function automatic int wr_cyc(input logic [31:0] a, input int k);
    int m = 0;
    for (int i = wbase; i < wq.size(); i++) begin
      if (wq[i].addr == a) begin
        if (m == k) return wq[i].cyc;
        m++;
      end
    end
    return -100000;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_in_ready"},  32'(in_ready),  32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_err"},       32'(err),       32'd0);
    check({tag, "_rnn_read"},  32'(rnn_read),  32'd0);
    check({tag, "_rnn_write"}, 32'(rnn_write), 32'd0);
    check({tag, "_rnn_addr"},  rnn_addr,       32'd0);
    check({tag, "_rnn_wdata"}, rnn_wdata,      32'd0);
    check({tag, "_res_data"},  32'(res_data),  32'd0);
  endtask

  vec_t        t1[11];
  logic [31:0] t3_exp[4];
  int          n;

  initial begin
    // Two characters of four elements, kick after each, then the dense trigger.
    t1[0]  = '{16'h0100, 32'd1, 32'h00000100};
    t1[1]  = '{16'h0080, 32'd1, 32'h00010080};
    t1[2]  = '{16'hFF00, 32'd1, 32'h0002FF00};
    t1[3]  = '{16'h0040, 32'd1, 32'h00030040};
    t1[4]  = '{16'h0000, 32'd0, 32'h00000000};
    t1[5]  = '{16'h0100, 32'd1, 32'h00000100};
    t1[6]  = '{16'h0080, 32'd1, 32'h00010080};
    t1[7]  = '{16'hFF00, 32'd1, 32'h0002FF00};
    t1[8]  = '{16'h0040, 32'd1, 32'h00030040};
    t1[9]  = '{16'h0000, 32'd0, 32'h00000000};
    t1[10] = '{16'h0000, 32'd7, 32'h00000000};
    t3_exp[0] = 32'h00000A00;
    t3_exp[1] = 32'h00010A01;
    t3_exp[2] = 32'h00020A02;
    t3_exp[3] = 32'h00030A03;

    rst = 1'b1; start = 1'b0; seq_len = '0; in_valid = 1'b0; in_data = '0; res_ack = 1'b0;
    tick();
    tick();
    check_outputs_zero("reset");
    rst = 1'b0;
    tick();

    // 1) seq_len=2 with table-driven elements
    begin_test(3, 32'hABCD1234);
    do_start(8'd2);
    for (int k = 0; k < 11; k++) if (t1[k].addr == 32'd1) send(t1[k].din, 1'b0);
    in_valid = 1'b0;
    wait_res("t1_res_valid");
    check("t1_nwrites", 32'(wq.size() - wbase), 32'd11);
    for (int k = 0; k < 11; k++) begin
      if (wbase + k < wq.size()) begin
        check($sformatf("t1_addr%0d", k),  wq[wbase+k].addr, t1[k].addr);
        check($sformatf("t1_wdata%0d", k), wq[wbase+k].data, t1[k].wdata);
      end
    end
    check("t1_res_data", 32'(res_data), 32'h00001234);
    ack();
    check("t1_busy_after_ack", 32'(busy), 32'd0);

    // 2) seq_len=0 goes straight to the dense trigger
    begin_test(1, 32'h00000042);
    do_start(8'd0);
    check("t2_write", 32'(rnn_write), 32'd1);
    check("t2_addr", rnn_addr, 32'd7);
    check("t2_wdata", rnn_wdata, 32'd0);
    wait_res("t2_res_valid");
    check("t2_n_addr1", 32'(n_writes(32'd1)), 32'd0);
    check("t2_n_addr0", 32'(n_writes(32'd0)), 32'd0);
    check("t2_n_addr7", 32'(n_writes(32'd7)), 32'd1);
    check("t2_res_data", 32'(res_data), 32'h00000042);
    ack();

    // 3) in_valid toggling every other cycle
    begin_test(2, 32'h00005555);
    do_start(8'd1);
    for (int i = 0; i < 4; i++) send(16'h0A00 + 16'(i), 1'b1);
    wait_res("t3_res_valid");
    check("t3_n_addr1", 32'(n_writes(32'd1)), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (wbase + i < wq.size()) check($sformatf("t3_wdata%0d", i), wq[wbase+i].data, t3_exp[i]);
    end
    for (int i = 1; i < 4; i++)
      check($sformatf("t3_gap%0d", i), 32'(wr_cyc(32'd1, i) - wr_cyc(32'd1, i - 1)), 32'd2);
    check("t3_wait_len", 32'(wr_cyc(32'd7, 0) - wr_cyc(32'd0, 0)), 32'(STEP_WAIT + 1));
    ack();

    // 4) latency with in_valid held high, VALID on 5th poll, result held until ack
    in_valid = 1'b1;
    in_data  = 16'h0011;
    begin_test(5, 32'h0000FFF0);
    start   = 1'b1;
    seq_len = 8'd1;
    n = 0;
    while (!res_valid && n < 500) begin
      tick();
      n++;
      if (n == 1) start = 1'b0;
    end
    in_valid = 1'b0;
    check("t4_latency", 32'(n), 32'd77);
    check("t4_polls", 32'(poll_cnt - poll_base), 32'd5);
    check("t4_res_data", 32'(res_data), 32'h0000FFF0);
    repeat (10) tick();
    check("t4_held_valid", 32'(res_valid), 32'd1);
    check("t4_held_data", 32'(res_data), 32'h0000FFF0);
    check("t4_held_busy", 32'(busy), 32'd1);
    ack();
    check("t4_valid_after_ack", 32'(res_valid), 32'd0);
    check("t4_busy_after_ack", 32'(busy), 32'd0);
    check("t4_data_kept", 32'(res_data), 32'h0000FFF0);

    // 5) poll timeout raises sticky err; next start clears it
    begin_test(0, 32'd0);
    do_start(8'd0);
    n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_err", 32'(err), 32'd1);
    check("t5_res_valid", 32'(res_valid), 32'd0);
    check("t5_polls", 32'(poll_cnt - poll_base), 32'(POLL_TIMEOUT));
    repeat (3) tick();
    check("t5_err_sticky", 32'(err), 32'd1);
    begin_test(1, 32'h00000077);
    do_start(8'd0);
    check("t5_err_cleared", 32'(err), 32'd0);
    check("t5_busy_restart", 32'(busy), 32'd1);
    wait_res("t5_res_valid2");
    ack();

    // 6) start during WAIT_STEP is ignored
    in_valid = 1'b1;
    in_data  = 16'h0101;
    begin_test(1, 32'h00000009);
    do_start(8'd1);
    repeat (20) tick();
    start   = 1'b1;
    seq_len = 8'd0;
    tick();
    start   = 1'b0;
    check("t6_busy", 32'(busy), 32'd1);
    check("t6_no_write", 32'(rnn_write), 32'd0);
    check("t6_in_ready", 32'(in_ready), 32'd0);
    wait_res("t6_res_valid");
    check("t6_n_addr1", 32'(n_writes(32'd1)), 32'd4);
    check("t6_wait_len", 32'(wr_cyc(32'd7, 0) - wr_cyc(32'd0, 0)), 32'(STEP_WAIT + 1));
    check("t6_res_data", 32'(res_data), 32'h00000009);
    ack();

    // 6b) reset asserted mid WAIT_STEP
    begin_test(0, 32'd0);
    do_start(8'd1);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    check_outputs_zero("t6_rst");
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    check("t6_idle_after_rst", 32'(busy), 32'd0);

    check("bus_exclusive", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
